alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between N_REQ requesters, e.g. the EX stage and the branch-compare/address unit. Requesters use valid/ready handshakes. The block applies round-robin arbitration with an optional short lock for back-to-back ops from one owner. It drives the ALU operand/op inputs combinationally, registers the ALU result and zero flag, and returns them tagged with the requester id.

---
 rtl/alu_pkg.sv | 19 +
 rtl/rr_pick.sv | 40 ++++
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic.
// Holds the ALU op encodings, the datapath widths and the lock FSM state type.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot selector.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index with the highest priority this cycle
//   en    - when low nothing is picked
//   gnt   - one-hot pick, only ever set on a requesting bit
//   idx   - binary index of the pick (0 when nothing picked)
//   found - high when a pick was made
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    // Walk the requesters starting at ptr and wrapping; the first one seen wins.
    always_comb begin
        int j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                j = (int'(ptr) + k) % N;
                if (!found && req[j]) begin
                    found  = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between N_REQ requesters.
// Round-robin arbitration with an optional time-limited lock so one owner can
// issue back-to-back ops. ALU inputs are driven combinationally from the granted
// requester; the ALU result and zero flag are registered and returned tagged
// with the owner's id.
// Ports:
//   clk, rst        - clock (rising edge) and synchronous active-high reset
//   req_valid/ready - per-requester handshake, ready is a one-hot grant
//   req_lock        - with an accepted request, keep the grant for later ops
//   req_a/b/op      - packed per-requester operands and op code
//   alu_a/b/op      - to the shared ALU (zero when nothing granted)
//   alu_res/zero    - combinational ALU outputs
//   rsp_valid/id/res/zero - registered response
//   rsp_ready       - per-requester response accept
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int LOCK_MAX = 4,
    parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_op,
    input  logic [DATA_W-1:0]       alu_res,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_res,
    output logic                    rsp_zero,
    input  logic [N_REQ-1:0]        rsp_ready
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

    lock_state_t     state, state_next;
    logic [ID_W-1:0] lock_owner, owner_next;
    logic [3:0]      lock_cnt, cnt_next;
    logic [ID_W-1:0] rr_ptr, ptr_next;

    logic             can_issue;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept;
    logic [N_REQ-1:0] rr_gnt;
    logic [ID_W-1:0]  rr_idx;
    logic             rr_found;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
        wrap_inc = (x == ID_W'(N_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // A new op may only issue when the response register is free or being drained.
    assign can_issue = !rsp_valid || rsp_ready[rsp_id];

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (can_issue && (state == UNLOCKED)),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // While locked only the owner can be granted, even if others are waiting.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        if (state == LOCKED) begin
            if (can_issue && req_valid[lock_owner]) begin
                gnt[lock_owner] = 1'b1;
                gnt_idx         = lock_owner;
                accept          = 1'b1;
            end
        end else begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
            accept  = rr_found;
        end
    end

    assign req_ready = gnt;

    // Mux the granted requester onto the ALU; idle ALU inputs are held at zero.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                alu_a  = req_a[DATA_W*i +: DATA_W];
                alu_b  = req_b[DATA_W*i +: DATA_W];
                alu_op = req_op[OP_W*i +: OP_W];
            end
        end
    end

    // Lock FSM and round-robin pointer. Only unlocked grants advance the pointer;
    // a forced release hands priority to the requester after the owner, and it
    // wins even if the owner is accepted with req_lock still high that cycle.
    always_comb begin
        state_next = state;
        owner_next = lock_owner;
        cnt_next   = lock_cnt;
        ptr_next   = rr_ptr;
        case (state)
            UNLOCKED: begin
                if (accept) begin
                    ptr_next = wrap_inc(gnt_idx);
                    if (req_lock[gnt_idx]) begin
                        state_next = LOCKED;
                        owner_next = gnt_idx;
                        cnt_next   = '0;
                    end
                end
            end
            LOCKED: begin
                cnt_next = lock_cnt + 4'd1;
                if (lock_cnt == LOCK_LAST) begin
                    state_next = UNLOCKED;
                    ptr_next   = wrap_inc(lock_owner);
                    cnt_next   = '0;
                end else if (accept && !req_lock[lock_owner]) begin
                    state_next = UNLOCKED;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= UNLOCKED;
            lock_owner <= '0;
            lock_cnt   <= '0;
            rr_ptr     <= '0;
        end else begin
            state      <= state_next;
            lock_owner <= owner_next;
            lock_cnt   <= cnt_next;
            rr_ptr     <= ptr_next;
        end
    end

    // Response register: a new accept overwrites a response consumed this cycle,
    // which gives back-to-back responses at full rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_res   <= '0;
            rsp_zero  <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_res   <= alu_res;
            rsp_zero  <= alu_zero;
        end else if (rsp_valid && rsp_ready[rsp_id]) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters and LOCK_MAX=4.
// A small behavioural ALU closes the loop from alu_a/b/op back to alu_res/zero.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_lock;
    logic [63:0]   req_a;
    logic [63:0]   req_b;
    logic [5:0]    req_op;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [2:0]    alu_op;
    logic [31:0]   alu_res;
    logic          alu_zero;
    logic          rsp_valid;
    logic [0:0]    rsp_id;
    logic [31:0]   rsp_res;
    logic          rsp_zero;
    logic [N-1:0]  rsp_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_arbiter #(.N_REQ(2), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_lock  (req_lock),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; unknown op codes give 0.
    always_comb begin
        case (alu_op)
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_SLT:  alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_res = 32'd0;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    // Inputs change one time unit after the rising edge, checks follow after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[3*i +: 3]  = op;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_lock = '0; req_a = '0; req_b = '0;
        req_op = '0; rsp_ready = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_res !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_rsp_res: got %h expected 0", rsp_res); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_id: got %b expected 0", rsp_id); end
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_fail++; $display("[TB] FAIL reset_alu_idle: got %h/%h/%b expected 0/0/000", alu_a, alu_b, alu_op); end
    endtask

    task automatic test_single();
        tick();
        set_req(0, 32'd5, 32'd3, OP_ADD);
        req_valid = 2'b01; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 01", req_ready); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== {32'd5, 32'd3, OP_ADD}) begin n_fail++; $display("[TB] FAIL single_alu_in: got %h/%h/%b expected 5/3/010", alu_a, alu_b, alu_op); end
        tick();
        req_valid = 2'b00;
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res, rsp_zero} !== {1'b1, 1'b0, 32'd8, 1'b0}) begin n_fail++; $display("[TB] FAIL single_rsp: got v=%b id=%0d res=%0d z=%b expected v=1 id=0 res=8 z=0", rsp_valid, rsp_id, rsp_res, rsp_zero); end
        #1;
        n_cmp++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_fail++; $display("[TB] FAIL single_alu_idle: got %h/%h/%b expected 0/0/000", alu_a, alu_b, alu_op); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drain: got %b expected 0", rsp_valid); end
    endtask

    // The pointer sits at 1 after the single op to requester 0, so requester 1 goes first.
    task automatic test_contention();
        logic [1:0] exp_g [4];
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
        set_req(0, 32'd7, 32'd7, OP_SUB);
        set_req(1, 32'd7, 32'd7, OP_SUB);
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (req_ready !== exp_g[k]) begin n_fail++; $display("[TB] FAIL contention_grant%0d: got %b expected %b", k, req_ready, exp_g[k]); end
            tick();
            n_cmp++; if ({rsp_valid, rsp_id, rsp_res, rsp_zero} !== {1'b1, exp_g[k][1], 32'd0, 1'b1}) begin n_fail++; $display("[TB] FAIL contention_rsp%0d: got v=%b id=%0d res=%0d z=%b expected v=1 id=%0d res=0 z=1", k, rsp_valid, rsp_id, rsp_res, rsp_zero, exp_g[k][1]); end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        set_req(0, 32'd10, 32'd4, OP_ADD);
        req_valid = 2'b01; rsp_ready = 2'b00;
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'd14}) begin n_fail++; $display("[TB] FAIL bp_first_rsp: got v=%b id=%0d res=%0d expected v=1 id=0 res=14", rsp_valid, rsp_id, rsp_res); end
        set_req(1, 32'd2, 32'd3, OP_OR);
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL bp_stall_ready%0d: got %b expected 00", k, req_ready); end
            tick();
            n_cmp++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'd14}) begin n_fail++; $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d res=%0d expected v=1 id=0 res=14", k, rsp_valid, rsp_id, rsp_res); end
        end
        rsp_ready = 2'b01;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b expected 10", req_ready); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res, rsp_zero} !== {1'b1, 1'b1, 32'd3, 1'b0}) begin n_fail++; $display("[TB] FAIL bp_next_rsp: got v=%b id=%0d res=%0d z=%b expected v=1 id=1 res=3 z=0", rsp_valid, rsp_id, rsp_res, rsp_zero); end
        req_valid = 2'b00; rsp_ready = 2'b11;
        tick();
    endtask

    // Pointer is 0 here; requester 1 locks, then is forced off after four locked cycles.
    task automatic test_lock();
        set_req(1, 32'hFFFF_FFFF, 32'd1, OP_SLT);
        set_req(0, 32'd1, 32'd1, OP_AND);
        req_valid = 2'b10; req_lock = 2'b10; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL lock_first_ready: got %b expected 10", req_ready); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res, rsp_zero} !== {1'b1, 1'b1, 32'd1, 1'b0}) begin n_fail++; $display("[TB] FAIL lock_slt_rsp: got v=%b id=%0d res=%0d z=%b expected v=1 id=1 res=1 z=0", rsp_valid, rsp_id, rsp_res, rsp_zero); end
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL lock_hold_ready%0d: got %b expected 10", k, req_ready); end
            tick();
        end
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL lock_forced_release: got %b expected 01", req_ready); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'd1}) begin n_fail++; $display("[TB] FAIL lock_after_rsp: got v=%b id=%0d res=%0d expected v=1 id=0 res=1", rsp_valid, rsp_id, rsp_res); end
        req_valid = 2'b00; req_lock = 2'b00;
        tick();
    endtask

    // Pointer is 1 here; requester 1 locks then goes idle, starving requester 0 until release.
    task automatic test_lock_idle();
        set_req(1, 32'd1, 32'd1, OP_ADD);
        req_valid = 2'b10; req_lock = 2'b10; rsp_ready = 2'b11;
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b1, 32'd2}) begin n_fail++; $display("[TB] FAIL idle_lock_rsp: got v=%b id=%0d res=%0d expected v=1 id=1 res=2", rsp_valid, rsp_id, rsp_res); end
        req_valid = 2'b01; req_lock = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_starve%0d: got %b expected 00", k, req_ready); end
            tick();
        end
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL idle_release: got %b expected 01", req_ready); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id} !== {1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL idle_after_rsp: got v=%b id=%0d expected v=1 id=0", rsp_valid, rsp_id); end
        req_valid = 2'b00;
        tick();
    endtask

    // Pointer is 1 here; lock requester 1 with a pending response, then reset.
    task automatic test_reset_mid();
        set_req(1, 32'd9, 32'd1, OP_ADD);
        set_req(0, 32'd4, 32'd4, OP_ADD);
        req_valid = 2'b10; req_lock = 2'b10; rsp_ready = 2'b00;
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b1, 32'd10}) begin n_fail++; $display("[TB] FAIL rmid_pre_rsp: got v=%b id=%0d res=%0d expected v=1 id=1 res=10", rsp_valid, rsp_id, rsp_res); end
        rst = 1'b1; req_valid = 2'b00;
        tick();
        rst = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res, rsp_zero} !== 35'd0) begin n_fail++; $display("[TB] FAIL rmid_rsp_cleared: got v=%b id=%0d res=%0d z=%b expected all 0", rsp_valid, rsp_id, rsp_res, rsp_zero); end
        req_valid = 2'b11; req_lock = 2'b00;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL rmid_first_grant: got %b expected 01", req_ready); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'd8}) begin n_fail++; $display("[TB] FAIL rmid_rsp: got v=%b id=%0d res=%0d expected v=1 id=0 res=8", rsp_valid, rsp_id, rsp_res); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        $display("[TB] alu_arbiter directed bench start");
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_lock();
        test_lock_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
